// File: rtl/memory_island_pkg.sv
// Shared types and helpers for the memory-island bank arbiter.
package memory_island_pkg;

  // Which port owns the response returning from the bank next cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_NARROW = 2'd1,
    SRC_WIDE   = 2'd2
  } src_e;

  // Width able to index/count n distinct values, never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_island_bank_arb_rr.sv
// Round-robin arbiter for the narrow requesters; pointer advances past each winner.
module memory_island_bank_arb_rr
  import memory_island_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdxW   = cnt_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] rr_q;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int off = 0; off < NumReq; off++) begin
      j = int'(rr_q) + off;
      if (j >= NumReq) j = j - NumReq;
      if (en_i && !valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (valid_o) begin
      rr_q <= (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + IdxW'(1);
    end
  end

endmodule

// File: rtl/memory_island_bank_arb.sv
// Single SRAM bank shared by round-robin narrow ports and one wide port
// with a starvation override; responses return one cycle after the grant.
module memory_island_bank_arb
  import memory_island_pkg::*;
#(
  parameter int NumNarrow        = 2,
  parameter int BankAddrWidth    = 10,
  parameter int DataWidth        = 64,
  parameter int WidePriorityWait = 4,
  parameter int StrbWidth        = DataWidth / 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumNarrow-1:0]                   narrow_req_i,
  output logic [NumNarrow-1:0]                   narrow_gnt_o,
  input  logic [NumNarrow-1:0][BankAddrWidth-1:0] narrow_addr_i,
  input  logic [NumNarrow-1:0]                   narrow_we_i,
  input  logic [NumNarrow-1:0][DataWidth-1:0]    narrow_wdata_i,
  input  logic [NumNarrow-1:0][StrbWidth-1:0]    narrow_strb_i,
  output logic [NumNarrow-1:0]                   narrow_rvalid_o,
  output logic [DataWidth-1:0]                   narrow_rdata_o,
  input  logic                                   wide_req_i,
  output logic                                   wide_gnt_o,
  input  logic [BankAddrWidth-1:0]               wide_addr_i,
  input  logic                                   wide_we_i,
  input  logic [DataWidth-1:0]                   wide_wdata_i,
  input  logic [StrbWidth-1:0]                   wide_strb_i,
  output logic                                   wide_rvalid_o,
  output logic [DataWidth-1:0]                   wide_rdata_o,
  output logic                                   bank_req_o,
  output logic                                   bank_we_o,
  output logic [BankAddrWidth-1:0]               bank_addr_o,
  output logic [DataWidth-1:0]                   bank_wdata_o,
  output logic [StrbWidth-1:0]                   bank_strb_o,
  input  logic [DataWidth-1:0]                   bank_rdata_i
);

  localparam int IdxW  = cnt_width(NumNarrow);
  localparam int WaitW = cnt_width(WidePriorityWait + 1);

  logic            override;
  logic            nar_valid;
  logic [IdxW-1:0] nar_idx;
  logic [NumNarrow-1:0] nar_gnt;
  src_e            resp_src_q;
  logic [IdxW-1:0] resp_idx_q;

  memory_island_bank_arb_rr #(
    .NumReq (NumNarrow),
    .IdxW   (IdxW)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (narrow_req_i),
    .en_i    (!override),
    .gnt_o   (nar_gnt),
    .idx_o   (nar_idx),
    .valid_o (nar_valid)
  );

  assign narrow_gnt_o = nar_gnt;
  assign wide_gnt_o   = wide_req_i && (override || !(|narrow_req_i));
  assign bank_req_o   = wide_gnt_o || nar_valid;

  // Starvation counter; cleared when the wide port is served or withdraws.
  if (WidePriorityWait > 0) begin : g_wait
    logic [WaitW-1:0] wait_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || wide_gnt_o || !wide_req_i) begin
        wait_q <= '0;
      end else if (wait_q != WaitW'(WidePriorityWait)) begin
        wait_q <= wait_q + WaitW'(1);
      end
    end
    assign override = wide_req_i && (wait_q == WaitW'(WidePriorityWait));
  end else begin : g_no_wait
    assign override = 1'b0;
  end

  always_comb begin
    bank_we_o    = narrow_we_i[nar_idx];
    bank_addr_o  = narrow_addr_i[nar_idx];
    bank_wdata_o = narrow_wdata_i[nar_idx];
    bank_strb_o  = narrow_strb_i[nar_idx];
    if (wide_gnt_o) begin
      bank_we_o    = wide_we_i;
      bank_addr_o  = wide_addr_i;
      bank_wdata_o = wide_wdata_i;
      bank_strb_o  = wide_strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_src_q <= SRC_NONE;
      resp_idx_q <= '0;
    end else begin
      resp_src_q <= wide_gnt_o ? SRC_WIDE : (nar_valid ? SRC_NARROW : SRC_NONE);
      resp_idx_q <= nar_idx;
    end
  end

  // rvalid is masked by reset so a response in flight when reset hits is dropped.
  always_comb begin
    narrow_rvalid_o = '0;
    for (int i = 0; i < NumNarrow; i++) begin
      if (!rst_i && resp_src_q == SRC_NARROW && resp_idx_q == IdxW'(i))
        narrow_rvalid_o[i] = 1'b1;
    end
  end

  assign wide_rvalid_o  = !rst_i && (resp_src_q == SRC_WIDE);
  assign narrow_rdata_o = bank_rdata_i;
  assign wide_rdata_o   = bank_rdata_i;

endmodule
